// File: rtl/serdes_pkg.sv
// Shared framing constants and input-FSM state encoding for the serializer/deserializer pair.
package serdes_pkg;

   localparam logic [7:0] HEADER_BYTE  = 8'hA5;
   localparam logic [7:0] TRAILER_BYTE = 8'h5A;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CHK     = 2'd2,
      ST_TRAILER = 2'd3
   } state_t;

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two-bank frame store: write side fills one bank while the read side replays the other
// on a ready/valid port; full flags track which banks hold committed frames.
module frame_pingpong_buf #(
   parameter int DATA_W      = 8,
   parameter int NUM_SAMPLES = 16,
   parameter int IDX_W       = $clog2(NUM_SAMPLES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              commit,
   output logic              wr_full,
   output logic              wr_free_now,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              dout_last,
   input  logic              dout_ready
);

   logic [DATA_W-1:0] mem [2][NUM_SAMPLES];

   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
   logic [1:0]        full_q, full_d;
   logic [DATA_W-1:0] dout_q;
   logic              valid_q, last_q;
   logic              fire, free;

   assign fire        = valid_q && dout_ready;
   assign free        = fire && (rd_idx_q == IDX_W'(NUM_SAMPLES - 1));
   assign wr_full     = full_q[wr_bank_q];
   assign wr_free_now = free && (rd_bank_q == wr_bank_q);

   // Clear-then-set so a bank freed and recommitted on the same edge stays full.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign full_d[gi] = (full_q[gi] && !(free && rd_bank_q == 1'(gi)))
                        || (commit && wr_bank_q == 1'(gi));
   end

   always_comb begin
      wr_bank_d = commit ? ~wr_bank_q : wr_bank_q;
      rd_bank_d = free ? ~rd_bank_q : rd_bank_q;
      rd_idx_d  = rd_idx_q;
      if (free)
         rd_idx_d = '0;
      else if (fire)
         rd_idx_d = rd_idx_q + IDX_W'(1);
   end

   // Writes into a bank still awaiting replay are suppressed; the top drops that frame.
   always_ff @(posedge clk) begin
      if (wr_en && !full_q[wr_bank_q])
         mem[wr_bank_q][wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         rd_idx_q  <= '0;
         full_q    <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         rd_idx_q  <= rd_idx_d;
         full_q    <= full_d;
         dout_q    <= mem[rd_bank_d][rd_idx_d];
         valid_q   <= full_d[rd_bank_d];
         last_q    <= full_d[rd_bank_d] && (rd_idx_d == IDX_W'(NUM_SAMPLES - 1));
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign dout_last  = last_q;

endmodule

// File: rtl/packet_deserializer.sv
// Frame hunter/checker feeding a ping-pong replay buffer. Define FRAME_CHECKSUM_EN to expect
// an XOR checksum byte between the payload and the trailer.
module packet_deserializer
   import serdes_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int NUM_SAMPLES = 16,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              dout_last,
   input  logic              dout_ready,
   output logic              err_frame,
   output logic              err_chk,
   output logic              err_ovf,
   output logic [CNT_W-1:0]  frames_ok
);

   localparam int IDX_W = $clog2(NUM_SAMPLES);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              ovf_q, ovf_d;
   logic              err_frame_q, err_frame_d;
   logic              err_chk_q, err_chk_d;
   logic              err_ovf_q, err_ovf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_en, commit, wr_full, wr_free_now, chk_fail;

`ifdef FRAME_CHECKSUM_EN
   logic [DATA_W-1:0] chk_q, chk_d;
   logic              chk_bad_q, chk_bad_d;
   assign chk_fail = chk_bad_q;
`else
   assign chk_fail = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      ovf_d       = ovf_q;
      err_frame_d = 1'b0;
      err_chk_d   = 1'b0;
      err_ovf_d   = 1'b0;
      cnt_d       = cnt_q;
      wr_en       = 1'b0;
      commit      = 1'b0;
`ifdef FRAME_CHECKSUM_EN
      chk_d       = chk_q;
      chk_bad_d   = chk_bad_q;
`endif
      if (din_valid) begin
         case (state_q)
            ST_HUNT: begin
               if (din == DATA_W'(HEADER_BYTE)) begin
                  state_d = ST_PAYLOAD;
                  idx_d   = '0;
                  ovf_d   = 1'b0;
`ifdef FRAME_CHECKSUM_EN
                  chk_d     = '0;
                  chk_bad_d = 1'b0;
`endif
               end
            end
            ST_PAYLOAD: begin
               wr_en = 1'b1;
               if (wr_full)
                  ovf_d = 1'b1;
`ifdef FRAME_CHECKSUM_EN
               chk_d = chk_q ^ din;
`endif
               if (idx_q == IDX_W'(NUM_SAMPLES - 1)) begin
`ifdef FRAME_CHECKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_TRAILER;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
            ST_CHK: begin
`ifdef FRAME_CHECKSUM_EN
               chk_bad_d = (din != chk_q);
               state_d   = ST_TRAILER;
`else
               state_d   = ST_HUNT;
`endif
            end
            ST_TRAILER: begin
               state_d = ST_HUNT;
               // A bank freed on this very edge counts as free, unless payload bytes were lost.
               if (din != DATA_W'(TRAILER_BYTE))
                  err_frame_d = 1'b1;
               else if (chk_fail)
                  err_chk_d = 1'b1;
               else if (ovf_q || (wr_full && !wr_free_now))
                  err_ovf_d = 1'b1;
               else begin
                  commit = 1'b1;
                  cnt_d  = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_HUNT;
         idx_q       <= '0;
         ovf_q       <= 1'b0;
         err_frame_q <= 1'b0;
         err_chk_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         ovf_q       <= ovf_d;
         err_frame_q <= err_frame_d;
         err_chk_q   <= err_chk_d;
         err_ovf_q   <= err_ovf_d;
         cnt_q       <= cnt_d;
      end
   end

`ifdef FRAME_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chk_q     <= '0;
         chk_bad_q <= 1'b0;
      end else begin
         chk_q     <= chk_d;
         chk_bad_q <= chk_bad_d;
      end
   end
`endif

   frame_pingpong_buf #(
      .DATA_W      (DATA_W),
      .NUM_SAMPLES (NUM_SAMPLES),
      .IDX_W       (IDX_W)
   ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_idx      (idx_q),
      .wr_data     (din),
      .commit      (commit),
      .wr_full     (wr_full),
      .wr_free_now (wr_free_now),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_last   (dout_last),
      .dout_ready  (dout_ready)
   );

   assign err_frame = err_frame_q;
   assign err_chk   = err_chk_q;
   assign err_ovf   = err_ovf_q;
   assign frames_ok = cnt_q;

endmodule

// File: tb/tb_packet_deserializer.sv
// Scoreboard bench for packet_deserializer: frames are judged by the framing rules when sent,
// and a monitor compares every replayed byte and error pulse against the queued expectations.
module tb_packet_deserializer;

   localparam int N = 16;
   typedef logic [7:0] frame_t [N];

`ifdef FRAME_CHECKSUM_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  din = '0;
   logic        din_valid = 1'b0;
   logic        dout_ready = 1'b1;
   logic [7:0]  dout;
   logic        dout_valid, dout_last;
   logic        err_frame, err_chk, err_ovf;
   logic [15:0] frames_ok;

   int errors = 0;
   int checks = 0;
   logic [8:0] exp_q[$];       // {last, byte}
   logic [2:0] err_exp_q[$];   // {ovf, chk, frame}
   int model_ok = 0;
   int committed = 0;
   int delivered = 0;
   int ready_mode = 1;         // 0 low, 1 high, 2 random

   always #5 clk = ~clk;

   packet_deserializer #(.DATA_W(8), .NUM_SAMPLES(N), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
      .err_frame(err_frame), .err_chk(err_chk), .err_ovf(err_ovf), .frames_ok(frames_ok)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       dout_ready = 1'b0;
            1:       dout_ready = 1'b1;
            default: dout_ready = ($urandom_range(3) != 0);
         endcase
      end
   end

   // Monitor: output handshakes and error pulses against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if (dout_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL dout_unexpected actual=%0h required=none", {dout_last, dout});
               end else begin
                  check("dout", {23'd0, dout_last, dout}, {23'd0, exp_q[0]});
                  if (dout_ready) begin
                     if (exp_q[0][8]) delivered++;
                     void'(exp_q.pop_front());
                  end
               end
            end
            if (err_frame || err_chk || err_ovf) begin
               if (err_exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL err_unexpected actual=%0b required=none", {err_ovf, err_chk, err_frame});
               end else begin
                  check("err", {29'd0, err_ovf, err_chk, err_frame}, {29'd0, err_exp_q[0]});
                  void'(err_exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic drive(input logic [7:0] b);
      @(posedge clk);
      #1;
      din = b;
      din_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         din_valid = 1'b0;
         din = 8'($urandom);
      end
   endtask

   task automatic send_frame(input frame_t pl, input logic [7:0] trl, input bit bad_chk,
                             input int gap_after, input int gap_len, input bit rnd_gaps);
      logic [7:0] x;
      x = '0;
      drive(8'hA5);
      for (int i = 0; i < N; i++) begin
         if (rnd_gaps && $urandom_range(4) == 0) idle($urandom_range(2, 1));
         drive(pl[i]);
         x ^= pl[i];
         if (i == gap_after) idle(gap_len);
      end
      if (CHK_ON) drive(bad_chk ? (x ^ 8'h01) : x);
      drive(trl);
      @(negedge clk);
      #1;
      if (trl != 8'h5A)
         err_exp_q.push_back(3'b001);
      else if (CHK_ON && bad_chk)
         err_exp_q.push_back(3'b010);
      else if (committed - delivered >= 2)
         err_exp_q.push_back(3'b100);
      else begin
         for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), pl[i]});
         committed++;
         model_ok++;
      end
      idle(1);
      @(negedge clk);
      check("frames_ok", {16'd0, frames_ok}, model_ok & 32'hFFFF);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic wait_space(input int budget);
      int n = 0;
      while (committed - delivered >= 2 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) check("space_timeout", committed - delivered, 1);
   endtask

   function automatic frame_t rand_frame();
      frame_t f;
      for (int i = 0; i < N; i++) f[i] = 8'($urandom);
      return f;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t f;
      int bubbles;
      logic [7:0] b;

      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout_last", dout_last, 0);
      check("rst_dout", dout, 0);
      check("rst_err_frame", err_frame, 0);
      check("rst_err_chk", err_chk, 0);
      check("rst_err_ovf", err_ovf, 0);
      check("rst_frames_ok", frames_ok, 0);

      // Counting payload, contiguous, then with a 3-cycle gap after byte 7.
      for (int i = 0; i < N; i++) f[i] = 8'(i);
      send_frame(f, 8'h5A, 1'b0, -1, 0, 1'b0);
      wait_drain(200);
      send_frame(f, 8'h5A, 1'b0, 7, 3, 1'b0);
      wait_drain(200);

      // Bad trailer, then a good frame.
      send_frame(rand_frame(), 8'h5B, 1'b0, -1, 0, 1'b0);
      send_frame(rand_frame(), 8'h5A, 1'b0, -1, 0, 1'b0);
      wait_drain(200);

      // Both banks filled while downstream stalls; the third frame overflows.
      ready_mode = 0;
      idle(2);
      for (int k = 0; k < 3; k++) send_frame(rand_frame(), 8'h5A, 1'b0, -1, 0, 1'b0);
      idle(3);
      check("stall_valid_held", dout_valid, 1);
      @(negedge clk);
      ready_mode = 1;
      @(posedge clk);
      #2;
      bubbles = 0;
      for (int i = 0; i < 2 * N; i++) begin
         @(negedge clk);
         if (!dout_valid) bubbles++;
      end
      check("b2b_bubbles", bubbles, 0);
      @(negedge clk);
      check("b2b_end_valid", dout_valid, 0);
      wait_drain(50);

      // Junk before the header; delimiter values inside the payload.
      drive(8'h11);
      drive(8'h22);
      f = rand_frame();
      f[2] = 8'hA5;
      f[5] = 8'h5A;
      f[N-1] = 8'hA5;
      send_frame(f, 8'h5A, 1'b0, -1, 0, 1'b0);
      wait_drain(200);

      // Reset in the middle of a payload.
      drive(8'hA5);
      for (int i = 0; i < 10; i++) drive(8'(i + 8'h30));
      #2 rst = 1'b0;
      din_valid = 1'b0;
      committed = 0;
      delivered = 0;
      model_ok = 0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check("midrst_frames_ok", frames_ok, 0);
      check("midrst_dout_valid", dout_valid, 0);
      send_frame(rand_frame(), 8'h5A, 1'b0, -1, 0, 1'b0);
      wait_drain(200);
      if (CHK_ON) begin
         send_frame(rand_frame(), 8'h5A, 1'b1, -1, 0, 1'b0);
         wait_drain(200);
      end

      // Randomized traffic with random backpressure, gaps, junk and corruption.
      ready_mode = 2;
      for (int k = 0; k < 30; k++) begin
         wait_space(2000);
         for (int j = 0; j < int'($urandom_range(2)); j++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            drive(b);
         end
         b = 8'h5A;
         if ($urandom_range(5) == 0) begin
            b = 8'($urandom);
            if (b == 8'h5A) b = 8'h5B;
         end
         send_frame(rand_frame(), b, ($urandom_range(5) == 0), -1, 0, 1'b1);
      end
      wait_drain(3000);
      idle(4);
      check("err_queue_empty", err_exp_q.size(), 0);
      check("byte_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
